// File: rtl/arb_pkg.sv
// Constants shared between the bus arbiter and its per-master requesters.
package arb_pkg;

  localparam int ARB_N  = 4;
  localparam int ARB_IW = $clog2(ARB_N);

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY    = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  localparam logic [ARB_IW-1:0] GNT_IDX_M0 = 2'd0;
  localparam logic [ARB_IW-1:0] GNT_IDX_M1 = 2'd1;
  localparam logic [ARB_IW-1:0] GNT_IDX_M2 = 2'd2;
  localparam logic [ARB_IW-1:0] GNT_IDX_M3 = 2'd3;

  // Index of the asserted bit of a one-hot arbiter grant vector.
  function automatic logic [ARB_IW-1:0] gnt_index(input logic [ARB_N-1:0] gnt);
    gnt_index = '0;
    for (int i = 0; i < ARB_N; i++) begin
      if (gnt[i]) gnt_index = ARB_IW'(i);
    end
  endfunction

endpackage

// File: rtl/req_timeout_cnt.sv
// Counts consecutive ungranted cycles; expire_o flags the last cycle before abort.
module req_timeout_cnt #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic inc_i,
  output logic expire_o
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  generate
    if (TIMEOUT == 0) begin : g_off
      logic w_unused;
      assign w_unused = &{1'b0, clk, rst, clear_i, inc_i};
      assign expire_o = 1'b0;
    end else begin : g_on
      localparam logic [TW-1:0] TERM = TW'(TIMEOUT - 1);
      logic [TW-1:0] r_tcnt;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_tcnt <= '0;
        end else if (clear_i) begin
          r_tcnt <= '0;
        end else if (inc_i) begin
          r_tcnt <= r_tcnt + TW'(1);
        end
      end

      assign expire_o = (r_tcnt == TERM);
    end
  endgenerate

endmodule

// File: rtl/bus_requester.sv
// Master-side burst agent: requests the arbiter, counts beats on granted cycles,
// releases the bus after the final beat or after a grant timeout.
//
//  state   | meaning
//  IDLE    | waiting for a command, cmd_ready_o high
//  BUSY    | req_o high, beats transfer on gnt_i cycles
//  RELEASE | req_o low for one cycle, stale grants ignored
module bus_requester
  import arb_pkg::*;
#(
  parameter int AW      = 16,
  parameter int LW      = 4,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [AW-1:0] cmd_addr_i,
  input  logic [LW-1:0] cmd_len_i,
  output logic          req_o,
  input  logic          gnt_i,
  output logic          beat_o,
  output logic [AW-1:0] addr_o,
  output logic          last_o,
  output logic          done_o,
  output logic          timeout_o,
  output logic          busy_o
);

  state_t        r_state;
  logic [AW-1:0] r_addr;
  logic [LW-1:0] r_remain;
  logic          r_done;
  logic          r_timeout;

  logic w_in_busy;
  logic w_accept;
  logic w_beat;
  logic w_last;
  logic w_expire;

  assign w_in_busy   = (r_state == ST_BUSY);
  assign cmd_ready_o = (r_state == ST_IDLE) & ~rst;
  assign w_accept    = cmd_valid_i & cmd_ready_o;
  assign w_beat      = w_in_busy & gnt_i;
  assign w_last      = w_beat & (r_remain == '0);

  assign req_o     = w_in_busy;
  assign busy_o    = (r_state != ST_IDLE);
  assign beat_o    = w_beat;
  assign last_o    = w_last;
  assign addr_o    = r_addr;
  assign done_o    = r_done;
  assign timeout_o = r_timeout;

  req_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_tcnt (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (w_accept | w_beat),
    .inc_i    (w_in_busy & ~gnt_i),
    .expire_o (w_expire)
  );

  // A beat always takes priority over an expiring timeout in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_remain  <= '0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr   <= cmd_addr_i;
            r_remain <= cmd_len_i;
            r_state  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_beat) begin
            r_addr <= r_addr + AW'(1);
            if (w_last) begin
              r_state <= ST_RELEASE;
              r_done  <= 1'b1;
            end else begin
              r_remain <= r_remain - LW'(1);
            end
          end else if (w_expire) begin
            r_state   <= ST_RELEASE;
            r_timeout <= 1'b1;
          end
        end
        ST_RELEASE: r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
